// File: rtl/icms_core.sv
// Integrated combat management core: weather-safety FSM (ECSU) plus a two-pulse
// radar ranging FSM (ARTAU) that flags approaching targets inside a range limit.
module icms_core #(
    parameter int CLK_PERIOD_US         = 100,
    parameter int PULSE_CYCLES          = 3,
    parameter int LISTEN_TIMEOUT_CYCLES = 20,
    parameter int ASSESS_TIMEOUT_CYCLES = 30,
    parameter int HALF_C_M_PER_US       = 150
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        radar_echo,
    input  logic        scan_for_target,
    input  logic [31:0] jet_speed,
    input  logic [31:0] max_safe_distance,
    input  logic [5:0]  wind,
    input  logic        thunderstorm,
    input  logic [1:0]  visibility,
    input  logic [7:0]  temperature,
    output logic        radar_pulse_trigger,
    output logic [31:0] distance_to_target,
    output logic        safe_to_engage,
    output logic        threat_detected,
    output logic        emergency_landing_alert,
    output logic [1:0]  ECSU_state,
    output logic [1:0]  ARTAU_state
);

    typedef enum logic [1:0] {ALL_NOMINAL, CAUTION, HIGH_ALERT, EMERGENCY} ecsu_t;
    typedef enum logic [1:0] {IDLE, EMIT, LISTEN, ASSESS} artau_t;

    ecsu_t  ecsu, ecsu_next;
    artau_t artau;

    logic signed [7:0] temp_s;
    logic ha, em, ca;

    assign temp_s = temperature;
    assign ha = thunderstorm | (wind > 6'd15) | (temp_s > 8'sd35) | (temp_s < -8'sd35)
              | (visibility == 2'b11);
    assign em = (wind > 6'd20) | (temp_s > 8'sd40) | (temp_s < -8'sd40);
    assign ca = (wind > 6'd10) | (visibility != 2'b00);

    always_comb begin
        ecsu_next = ecsu;
        case (ecsu)
            ALL_NOMINAL: if (ha) ecsu_next = HIGH_ALERT; else if (ca) ecsu_next = CAUTION;
            CAUTION:     if (ha) ecsu_next = HIGH_ALERT; else if (!ca) ecsu_next = ALL_NOMINAL;
            HIGH_ALERT:  if (em) ecsu_next = EMERGENCY; else if (!ha) ecsu_next = CAUTION;
            EMERGENCY:   ecsu_next = EMERGENCY;
        endcase
    end

    // Echo pulses may be narrower than a clock, so the echo edge toggles a flop in its
    // own domain and the CLK domain sees a pending echo until it copies the toggle back.
    logic echo_tog, echo_ack, echo_flag;

    always_ff @(posedge radar_echo)
        echo_tog <= ~echo_tog;

    always_ff @(posedge CLK)
        echo_ack <= echo_tog;

    assign echo_flag = echo_tog ^ echo_ack;

    logic [7:0]  timer, gap;
    logic [31:0] d1, echo_dist, dt_us;
    logic        second_pulse, threat_calc, threat_next;

    assign echo_dist = 32'(HALF_C_M_PER_US * CLK_PERIOD_US) * (32'(timer) + 32'd1);
    assign dt_us     = (32'(gap) + 32'd1) * 32'(CLK_PERIOD_US);
    assign threat_calc = (echo_dist < max_safe_distance) && (echo_dist < d1)
                       && ((64'(d1 - echo_dist) * 64'd1000000) > (64'(jet_speed) * 64'(dt_us)));

    always_comb begin
        threat_next = threat_detected;
        if (artau == LISTEN) begin
            if (echo_flag && second_pulse)
                threat_next = threat_calc;
            else if (!echo_flag && timer == 8'(LISTEN_TIMEOUT_CYCLES - 1))
                threat_next = 1'b0;
        end else if (artau == ASSESS && !scan_for_target
                     && timer == 8'(ASSESS_TIMEOUT_CYCLES - 1)) begin
            threat_next = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ecsu                    <= ALL_NOMINAL;
            emergency_landing_alert <= 1'b0;
            safe_to_engage          <= 1'b0;
        end else begin
            ecsu                    <= ecsu_next;
            emergency_landing_alert <= (ecsu_next == EMERGENCY);
            safe_to_engage          <= threat_next
                                       && (ecsu_next == ALL_NOMINAL || ecsu_next == CAUTION);
        end
    end

    // timer is shared by EMIT, LISTEN and ASSESS; gap counts clocks since the first echo.
    always_ff @(posedge CLK) begin
        if (RST) begin
            artau               <= IDLE;
            radar_pulse_trigger <= 1'b0;
            distance_to_target  <= 32'd0;
            threat_detected     <= 1'b0;
            timer               <= 8'd0;
            gap                 <= 8'd0;
            d1                  <= 32'd0;
            second_pulse        <= 1'b0;
        end else begin
            threat_detected <= threat_next;
            gap             <= gap + 8'd1;
            case (artau)
                IDLE: begin
                    if (scan_for_target) begin
                        artau               <= EMIT;
                        radar_pulse_trigger <= 1'b1;
                        timer               <= 8'd0;
                        second_pulse        <= 1'b0;
                    end
                end
                EMIT: begin
                    if (timer == 8'(PULSE_CYCLES - 1)) begin
                        artau               <= LISTEN;
                        radar_pulse_trigger <= 1'b0;
                        timer               <= 8'd0;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                LISTEN: begin
                    if (echo_flag) begin
                        distance_to_target <= echo_dist;
                        timer              <= 8'd0;
                        if (!second_pulse) begin
                            d1                  <= echo_dist;
                            gap                 <= 8'd0;
                            second_pulse        <= 1'b1;
                            artau               <= EMIT;
                            radar_pulse_trigger <= 1'b1;
                        end else begin
                            artau <= ASSESS;
                        end
                    end else if (timer == 8'(LISTEN_TIMEOUT_CYCLES - 1)) begin
                        artau              <= IDLE;
                        distance_to_target <= 32'd0;
                        timer              <= 8'd0;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                ASSESS: begin
                    if (scan_for_target) begin
                        artau               <= EMIT;
                        radar_pulse_trigger <= 1'b1;
                        timer               <= 8'd0;
                        second_pulse        <= 1'b0;
                    end else if (timer == 8'(ASSESS_TIMEOUT_CYCLES - 1)) begin
                        artau              <= IDLE;
                        distance_to_target <= 32'd0;
                        timer              <= 8'd0;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
            endcase
        end
    end

    assign ECSU_state  = ecsu;
    assign ARTAU_state = artau;

endmodule

// File: tb/tb_icms_core.sv
// Randomized and directed bench for icms_core against a transaction-level model of
// the weather grading rules and the two-pulse ranging sequence.
`timescale 1ns/1ps
module tb_icms_core;

    localparam longint unsigned RANGE_STEP = 150 * 100;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        radar_echo = 1'b0;
    logic        scan_for_target = 1'b0;
    logic [31:0] jet_speed = 32'd0;
    logic [31:0] max_safe_distance = 32'd0;
    logic [5:0]  wind;
    logic        thunderstorm;
    logic [1:0]  visibility;
    logic [7:0]  temperature;
    logic        radar_pulse_trigger;
    logic [31:0] distance_to_target;
    logic        safe_to_engage;
    logic        threat_detected;
    logic        emergency_landing_alert;
    logic [1:0]  ECSU_state;
    logic [1:0]  ARTAU_state;

    icms_core dut (
        .CLK(CLK), .RST(RST), .radar_echo(radar_echo), .scan_for_target(scan_for_target),
        .jet_speed(jet_speed), .max_safe_distance(max_safe_distance), .wind(wind),
        .thunderstorm(thunderstorm), .visibility(visibility), .temperature(temperature),
        .radar_pulse_trigger(radar_pulse_trigger), .distance_to_target(distance_to_target),
        .safe_to_engage(safe_to_engage), .threat_detected(threat_detected),
        .emergency_landing_alert(emergency_landing_alert),
        .ECSU_state(ECSU_state), .ARTAU_state(ARTAU_state)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int cur_wind, cur_vis, cur_temp;
    bit cur_th;
    int exp_ecsu = 0;
    longint unsigned exp_dist = 0;
    bit exp_threat = 0;
    bit rand_weather = 0;
    bit in_assess = 0;

    task automatic checkOutput(input string tag, input longint unsigned got,
                               input longint unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input int w, input bit th, input int vis, input int t_c);
        cur_wind = w; cur_th = th; cur_vis = vis; cur_temp = t_c;
        wind = 6'(w); thunderstorm = th; visibility = 2'(vis); temperature = 8'(t_c);
    endtask

    // Weather grading written straight from the rule table, using plain integers.
    function automatic int ecsu_model(input int s, input int w, input bit th,
                                      input int vis, input int t);
        bit ha = th || w > 15 || t > 35 || t < -35 || vis == 3;
        bit em = w > 20 || t > 40 || t < -40;
        bit ca = w > 10 || vis != 0;
        if (s == 0) return ha ? 2 : (ca ? 1 : 0);
        if (s == 1) return ha ? 2 : (!ca ? 0 : 1);
        if (s == 2) return em ? 3 : (!ha ? 1 : 2);
        return 3;
    endfunction

    task automatic step(input int exp_art, input bit exp_trig);
        if (rand_weather)
            applyStimulus(int'($urandom_range(0, 22)), ($urandom_range(0, 9) == 0),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 90)) - 45);
        @(posedge CLK);
        #1;
        cyc++;
        exp_ecsu = RST ? 0 : ecsu_model(exp_ecsu, cur_wind, cur_th, cur_vis, cur_temp);
        checkOutput("ecsu_state", ECSU_state, exp_ecsu);
        checkOutput("alert", emergency_landing_alert, exp_ecsu == 3);
        checkOutput("artau_state", ARTAU_state, exp_art);
        checkOutput("trigger", radar_pulse_trigger, exp_trig);
        checkOutput("distance", distance_to_target, exp_dist);
        checkOutput("threat", threat_detected, exp_threat);
        checkOutput("safe", safe_to_engage, exp_threat && exp_ecsu <= 1);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        exp_dist = 0;
        exp_threat = 0;
        in_assess = 0;
        step(0, 0);
        RST = 1'b0;
    endtask

    task automatic fire_echo();
        radar_echo = 1'b1;
        #($urandom_range(1, 3));
        radar_echo = 1'b0;
    endtask

    // k1/k2 are the LISTEN clock at which each echo is returned; 20 or more means silence.
    task automatic run_scan(input int k1, input int k2);
        int first_cyc = 0;
        longint unsigned d1 = 0, d2, dt_us, jet, lim;
        scan_for_target = 1'b1;
        step(1, 1);
        scan_for_target = 1'b0;
        step(1, 1); step(1, 1); step(2, 0);
        in_assess = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == k1) begin
                fire_echo();
                d1 = RANGE_STEP * longint'(i + 1);
                exp_dist = d1;
                step(1, 1);
                first_cyc = cyc;
                break;
            end
            if (i == 19) begin
                exp_dist = 0; exp_threat = 0;
                step(0, 0);
                return;
            end
            step(2, 0);
        end
        step(1, 1); step(1, 1); step(2, 0);
        for (int i = 0; i < 20; i++) begin
            if (i == k2) begin
                fire_echo();
                d2 = RANGE_STEP * longint'(i + 1);
                dt_us = longint'(cyc + 1 - first_cyc) * 100;
                jet = jet_speed;
                lim = max_safe_distance;
                exp_dist = d2;
                exp_threat = (d2 < lim) && (d2 < d1) && ((d1 - d2) * 1000000 > jet * dt_us);
                step(3, 0);
                in_assess = 1;
                return;
            end
            if (i == 19) begin
                exp_dist = 0; exp_threat = 0;
                step(0, 0);
                return;
            end
            step(2, 0);
        end
    endtask

    task automatic assess_timeout(input int already);
        for (int j = already; j < 29; j++) step(3, 0);
        exp_dist = 0; exp_threat = 0;
        step(0, 0);
        in_assess = 0;
    endtask

    initial begin
        applyStimulus(0, 0, 0, 20);
        do_reset();
        checkOutput("reset_ecsu", ECSU_state, 0);
        checkOutput("reset_dist", distance_to_target, 0);

        applyStimulus(12, 0, 0, 25); step(0, 0); checkOutput("to_caution", ECSU_state, 1);
        applyStimulus(5, 0, 0, 25);  step(0, 0); checkOutput("to_nominal", ECSU_state, 0);
        applyStimulus(5, 0, 1, 25);  step(0, 0); checkOutput("vis_caution", ECSU_state, 1);
        applyStimulus(5, 1, 1, 25);  step(0, 0); checkOutput("storm_high", ECSU_state, 2);
        applyStimulus(5, 0, 1, 25);  step(0, 0); checkOutput("storm_clear", ECSU_state, 1);
        applyStimulus(5, 0, 3, 25);  step(0, 0); checkOutput("poor_vis", ECSU_state, 2);
        applyStimulus(25, 0, 2, 25); step(0, 0); checkOutput("to_emerg", ECSU_state, 3);
        checkOutput("alert_on", emergency_landing_alert, 1);
        applyStimulus(0, 0, 0, 20);
        for (int i = 0; i < 3; i++) step(0, 0);
        checkOutput("emerg_sticky", ECSU_state, 3);

        do_reset();
        applyStimulus(15, 0, 1, 25);  step(0, 0); checkOutput("wind15", ECSU_state, 1);
        applyStimulus(15, 0, 1, 40);  step(0, 0); checkOutput("temp40", ECSU_state, 2);
        applyStimulus(25, 0, 1, -40); step(0, 0); checkOutput("em_from_ha", ECSU_state, 3);
        do_reset();
        applyStimulus(25, 0, 0, 20); step(0, 0); checkOutput("em_first_clk", ECSU_state, 2);
        step(0, 0); checkOutput("em_second_clk", ECSU_state, 3);

        do_reset();
        applyStimulus(0, 0, 0, 20);
        fire_echo(); step(0, 0);
        run_scan(0, 0);
        checkOutput("equal_range_dist", distance_to_target, 15000);
        checkOutput("equal_range_threat", threat_detected, 0);
        assess_timeout(0);

        jet_speed = 32'd7000; max_safe_distance = 32'd20000;
        run_scan(1, 0);
        checkOutput("approach_threat", threat_detected, 1);
        checkOutput("approach_safe", safe_to_engage, 1);
        applyStimulus(5, 1, 0, 20); step(3, 0);
        checkOutput("ha_blocks_safe", safe_to_engage, 0);
        applyStimulus(0, 0, 0, 20);
        assess_timeout(1);

        run_scan(25, 25);
        checkOutput("timeout_idle", ARTAU_state, 0);
        run_scan(19, 19);

        scan_for_target = 1'b1; step(1, 1);
        scan_for_target = 1'b0; step(1, 1); step(1, 1); step(2, 0);
        step(2, 0); step(2, 0);
        do_reset();
        checkOutput("mid_listen_rst", ARTAU_state, 0);

        rand_weather = 1;
        for (int i = 0; i < 120; i++) begin
            if (i % 40 == 0) do_reset();
            step(0, 0);
        end
        for (int n = 0; n < 16; n++) begin
            if (n % 4 == 0) do_reset();
            rand_weather = n[0];
            if (!rand_weather) applyStimulus(int'($urandom_range(0, 12)), 0, 0, 20);
            jet_speed = $urandom_range(0, 100000000);
            max_safe_distance = $urandom_range(0, 320000);
            run_scan(int'($urandom_range(0, 21)), int'($urandom_range(0, 21)));
            if (in_assess && $urandom_range(0, 1) == 1) assess_timeout(0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
